pc_redirect_unit: RTL and testbench

- Fetch-side consumer of the decode-stage branch decision. Holds the IF-stage PC and drives the instruction-fetch request.
- Applies branch/jump redirects after the architectural delay slot, and handles exception flush redirects.
- Holds a resolved redirect across fetch stalls until the delay-slot fetch is accepted.

---
 rtl/pc_redirect_unit.sv | 147 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// IF-stage PC holder: sequential fetch, delayed branch redirect after the delay slot, and flush redirect.
// Optional feature macro: BRANCH_STATS_EN (branch/taken counters; tied to zero when undefined).
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall_f,
   input  logic              flush,
   input  logic [ADDR_W-1:0] except_pc,
   input  logic              br_valid,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              inst_addr_ok,
   output logic              inst_req,
   output logic [ADDR_W-1:0] pc_f,
   output logic [ADDR_W-1:0] pc_plus4_f,
   output logic              in_delayslot_f,
   output logic              adel_f,
   output logic [31:0]       branch_cnt,
   output logic [31:0]       taken_cnt
);

   typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [ADDR_W-1:0] tgt_r, tgt_s;
   logic              ds_r, ds_s;
   logic              req_r;
   logic              accept_s;
   logic              br_evt_s;

   assign accept_s       = req_r & inst_addr_ok & ~stall_f;
   assign br_evt_s       = ~flush & (state_r == IDLE) & br_valid;
   assign inst_req       = req_r;
   assign pc_f           = pc_r;
   assign pc_plus4_f     = pc_r + 32'd4;
   assign in_delayslot_f = ds_r;
   assign adel_f         = (pc_r[1:0] != 2'b00);

   // Next-state selection: flush beats redirect, redirect beats sequential fetch.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      tgt_s   = tgt_r;
      ds_s    = ds_r;
      if (flush) begin
         pc_s    = except_pc;
         state_s = IDLE;
         ds_s    = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (br_valid) begin
                  // pc_f is the delay slot; the target is only fetched once it is accepted
                  if (br_taken) begin
                     if (accept_s) begin
                        pc_s = br_target;
                        ds_s = 1'b0;
                     end else begin
                        tgt_s   = br_target;
                        state_s = PEND;
                        ds_s    = 1'b1;
                     end
                  end else begin
                     if (accept_s) begin
                        pc_s = pc_r + 32'd4;
                        ds_s = 1'b0;
                     end else begin
                        ds_s = 1'b1;
                     end
                  end
               end else begin
                  if (accept_s) begin
                     pc_s = pc_r + 32'd4;
                     ds_s = 1'b0;
                  end else begin
                     pc_s = pc_r;
                  end
               end
            end
            PEND: begin
               // later br_valid pulses are ignored here: the first target wins
               if (accept_s) begin
                  pc_s    = tgt_r;
                  state_s = IDLE;
                  ds_s    = 1'b0;
               end else begin
                  pc_s = pc_r;
               end
            end
            default: begin
               state_s = IDLE;
               ds_s    = 1'b0;
            end
         endcase
      end
   end

   // Fetch PC, held target, delay-slot flag and request registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= IDLE;
         pc_r    <= RESET_PC;
         tgt_r   <= 32'h0000_0000;
         ds_r    <= 1'b0;
         req_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         tgt_r   <= tgt_s;
         ds_r    <= ds_s;
         req_r   <= 1'b1;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_cnt_r;
   logic [31:0] taken_cnt_r;

   // Saturating statistics counters for branches consumed in IDLE.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         branch_cnt_r <= 32'h0000_0000;
         taken_cnt_r  <= 32'h0000_0000;
      end else begin
         if (br_evt_s && (branch_cnt_r != 32'hFFFF_FFFF)) begin
            branch_cnt_r <= branch_cnt_r + 32'd1;
         end
         if (br_evt_s && br_taken && (taken_cnt_r != 32'hFFFF_FFFF)) begin
            taken_cnt_r <= taken_cnt_r + 32'd1;
         end
      end
   end

   assign branch_cnt = branch_cnt_r;
   assign taken_cnt  = taken_cnt_r;
`else
   logic unused_s;
   assign unused_s   = br_evt_s;
   assign branch_cnt = 32'h0000_0000;
   assign taken_cnt  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: reset, sequential fetch, taken/not-taken redirects, stalls, flush, wrap.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        resetn, stall_f, flush, br_valid, br_taken, inst_addr_ok;
   logic [31:0] except_pc, br_target;
   logic        inst_req, in_delayslot_f, adel_f;
   logic [31:0] pc_f, pc_plus4_f, branch_cnt, taken_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pc_redirect_unit dut (
      .clk(clk), .resetn(resetn), .stall_f(stall_f), .flush(flush),
      .except_pc(except_pc), .br_valid(br_valid), .br_taken(br_taken),
      .br_target(br_target), .inst_addr_ok(inst_addr_ok), .inst_req(inst_req),
      .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .in_delayslot_f(in_delayslot_f),
      .adel_f(adel_f), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush(input logic [31:0] addr);
      flush = 1'b1; except_pc = addr;
      step();
      flush = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; stall_f = 1'b0; flush = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
      inst_addr_ok = 1'b1; except_pc = 32'h0; br_target = 32'h0;
      step(); step();
      chk("rst_pc", pc_f, 32'hBFC0_0000);
      chk("rst_req", {31'd0, inst_req}, 32'd0);
      chk("rst_ds", {31'd0, in_delayslot_f}, 32'd0);
      chk("rst_adel", {31'd0, adel_f}, 32'd0);
      chk("rst_pc4", pc_plus4_f, 32'hBFC0_0004);
      chk("rst_bcnt", branch_cnt, 32'd0);
      chk("rst_tcnt", taken_cnt, 32'd0);

      resetn = 1'b1;
      step();
      chk("req_rise", {31'd0, inst_req}, 32'd1);
      chk("seq0", pc_f, 32'hBFC0_0000);
      step();
      chk("seq1", pc_f, 32'hBFC0_0004);
      step();
      chk("seq2", pc_f, 32'hBFC0_0008);

      // taken branch, delay slot accepted in the same cycle
      do_flush(32'h0000_1004);
      chk("flush_pc", pc_f, 32'h0000_1004);
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_2000;
      step();
      br_valid = 1'b0;
      chk("tk_acc_pc", pc_f, 32'h0000_2000);
      chk("tk_acc_ds", {31'd0, in_delayslot_f}, 32'd0);
      step();
      chk("tk_acc_seq", pc_f, 32'h0000_2004);

      // taken branch under a 3-cycle stall
      do_flush(32'h0000_1004);
      stall_f = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_2000;
      step();
      br_valid = 1'b0;
      chk("pend_pc0", pc_f, 32'h0000_1004);
      chk("pend_ds0", {31'd0, in_delayslot_f}, 32'd1);
      step(); step();
      chk("pend_pc2", pc_f, 32'h0000_1004);
      chk("pend_ds2", {31'd0, in_delayslot_f}, 32'd1);
      stall_f = 1'b0;
      step();
      chk("pend_rel_pc", pc_f, 32'h0000_2000);
      chk("pend_rel_ds", {31'd0, in_delayslot_f}, 32'd0);

      // not taken with and without accept
      do_flush(32'h0000_1004);
      br_valid = 1'b1; br_taken = 1'b0;
      step();
      chk("nt_acc_pc", pc_f, 32'h0000_1008);
      chk("nt_acc_ds", {31'd0, in_delayslot_f}, 32'd0);
      inst_addr_ok = 1'b0;
      step();
      br_valid = 1'b0; inst_addr_ok = 1'b1;
      chk("nt_hold_pc", pc_f, 32'h0000_1008);
      chk("nt_hold_ds", {31'd0, in_delayslot_f}, 32'd1);
      step();
      chk("nt_rel_pc", pc_f, 32'h0000_100C);
      chk("nt_rel_ds", {31'd0, in_delayslot_f}, 32'd0);

      // flush while PEND drops the held target
      stall_f = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_2000;
      step();
      br_valid = 1'b0;
      do_flush(32'hBFC0_0380);
      chk("pflush_pc", pc_f, 32'hBFC0_0380);
      chk("pflush_ds", {31'd0, in_delayslot_f}, 32'd0);
      stall_f = 1'b0;
      step();
      chk("pflush_seq", pc_f, 32'hBFC0_0384);

      // second pulse while PEND is ignored
      stall_f = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_4000;
      step();
      br_target = 32'h0000_5000;
      step();
      br_valid = 1'b0; stall_f = 1'b0;
      step();
      chk("first_wins", pc_f, 32'h0000_4000);

      // misaligned targets still load and raise adel_f
      do_flush(32'h0000_1002);
      chk("adel_flush", {31'd0, adel_f}, 32'd1);
      chk("adel_pc4", pc_plus4_f, 32'h0000_1006);
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0007;
      step();
      br_valid = 1'b0;
      chk("adel_tgt_pc", pc_f, 32'h0000_0007);
      chk("adel_tgt", {31'd0, adel_f}, 32'd1);

      // address wrap
      do_flush(32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus4_f, 32'h0000_0000);
      step();
      chk("wrap_pc", pc_f, 32'h0000_0000);
      chk("wrap_adel", {31'd0, adel_f}, 32'd0);

`ifdef BRANCH_STATS_EN
      chk("bcnt", branch_cnt, 32'd7);
      chk("tcnt", taken_cnt, 32'd5);
`else
      chk("bcnt", branch_cnt, 32'd0);
      chk("tcnt", taken_cnt, 32'd0);
`endif

      // reset while PEND loses the redirect
      stall_f = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_2000;
      step();
      br_valid = 1'b0; resetn = 1'b0;
      step();
      chk("rpend_pc", pc_f, 32'hBFC0_0000);
      chk("rpend_req", {31'd0, inst_req}, 32'd0);
      chk("rpend_ds", {31'd0, in_delayslot_f}, 32'd0);
      chk("rpend_bcnt", branch_cnt, 32'd0);
      resetn = 1'b1; stall_f = 1'b0;
      step();
      chk("rpend_pc1", pc_f, 32'hBFC0_0000);
      step();
      chk("rpend_pc2", pc_f, 32'hBFC0_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
